// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream with packet framing, driven by fifo_rd_stream.
interface fifo_rd_stream_if #(
    parameter int unsigned DATA_LEN = 32
);
    logic                m_valid;
    logic                m_ready;
    logic [DATA_LEN-1:0] m_data;
    logic                m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a 2-entry queue and presents it as a
// framed valid/ready stream at one word per rclk cycle.
module fifo_rd_stream #(
    parameter int unsigned DATA_LEN  = 32,
    parameter int unsigned PKT_LEN   = 16,
    parameter int unsigned PKT_CNT_W = 16
) (
    input  logic                 rclk,
    input  logic                 rst,
    input  logic                 rempty_i,
    input  logic [DATA_LEN-1:0]  rdata_i,
    output logic                 read_en_o,
    fifo_rd_stream_if.master     m,
    output logic [PKT_CNT_W-1:0] pkt_cnt_o
);
    localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(PKT_LEN - 1);

    logic [DATA_LEN-1:0]  mem_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;
    logic                 inflight_q;
    logic [BEAT_W-1:0]    beat_q;
    logic [PKT_CNT_W-1:0] pkt_cnt_q;

    logic       push;
    logic       pop;
    logic       last;
    logic [2:0] level;

    // Queue occupancy plus the word already in flight, net of this cycle's pop.
    // Counting the pop is what lets a full queue keep issuing at full rate.
    assign push      = inflight_q;
    assign pop       = m.m_valid & m.m_ready;
    assign level     = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign read_en_o = !rst && !rempty_i && (level < 3'd2);

    assign last      = (beat_q == BEAT_MAX);
    assign m.m_valid = (count_q != 2'd0);
    assign m.m_data  = mem_q[rd_ptr_q];
    assign m.m_last  = m.m_valid & last;
    assign pkt_cnt_o = pkt_cnt_q;

    // Queue storage; contents are don't-care until count says otherwise.
    always_ff @(posedge rclk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= rdata_i;
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            inflight_q <= read_en_o;
            count_q    <= count_q + 2'(push) - 2'(pop);
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                beat_q   <= last ? '0 : beat_q + BEAT_W'(1);
                if (last) begin
                    pkt_cnt_q <= pkt_cnt_q + PKT_CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: three builds (16/16, PKT_LEN=1, PKT_LEN=2 with
// a 2-bit packet counter), each fed by a behavioural FIFO read-port model.
module tb_fifo_rd_stream;
    localparam int unsigned DW = 32;

    typedef struct {
        logic        ready;
        logic        re;
        logic        valid;
        logic [31:0] data;
    } vec_t;

    logic rclk = 1'b0;
    logic rst  = 1'b1;
    always #5 rclk = ~rclk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // ---------------- build A: PKT_LEN=16, PKT_CNT_W=16
    logic          ready_a = 1'b0;
    logic          gate_a  = 1'b0;
    int unsigned   loaded_a = 0;
    int unsigned   popped_a = 0;
    logic          rempty_a;
    logic [DW-1:0] rdata_a = '0;
    logic          read_en_a;
    logic [15:0]   pkt_a;
    fifo_rd_stream_if #(.DATA_LEN(DW)) a_if ();
    assign a_if.m_ready = ready_a;
    assign rempty_a = (loaded_a == popped_a) || gate_a;

    fifo_rd_stream #(.DATA_LEN(DW), .PKT_LEN(16), .PKT_CNT_W(16)) dut_a (
        .rclk(rclk), .rst(rst), .rempty_i(rempty_a), .rdata_i(rdata_a),
        .read_en_o(read_en_a), .m(a_if), .pkt_cnt_o(pkt_a)
    );

    // ---------------- build B: PKT_LEN=1
    logic          ready_b = 1'b0;
    int unsigned   loaded_b = 0;
    int unsigned   popped_b = 0;
    logic          rempty_b;
    logic [DW-1:0] rdata_b = '0;
    logic          read_en_b;
    logic [15:0]   pkt_b;
    fifo_rd_stream_if #(.DATA_LEN(DW)) b_if ();
    assign b_if.m_ready = ready_b;
    assign rempty_b = (loaded_b == popped_b);

    fifo_rd_stream #(.DATA_LEN(DW), .PKT_LEN(1), .PKT_CNT_W(16)) dut_b (
        .rclk(rclk), .rst(rst), .rempty_i(rempty_b), .rdata_i(rdata_b),
        .read_en_o(read_en_b), .m(b_if), .pkt_cnt_o(pkt_b)
    );

    // ---------------- build C: PKT_LEN=2, PKT_CNT_W=2
    logic          ready_c = 1'b0;
    int unsigned   loaded_c = 0;
    int unsigned   popped_c = 0;
    logic          rempty_c;
    logic [DW-1:0] rdata_c = '0;
    logic          read_en_c;
    logic [1:0]    pkt_c;
    fifo_rd_stream_if #(.DATA_LEN(DW)) c_if ();
    assign c_if.m_ready = ready_c;
    assign rempty_c = (loaded_c == popped_c);

    fifo_rd_stream #(.DATA_LEN(DW), .PKT_LEN(2), .PKT_CNT_W(2)) dut_c (
        .rclk(rclk), .rst(rst), .rempty_i(rempty_c), .rdata_i(rdata_c),
        .read_en_o(read_en_c), .m(c_if), .pkt_cnt_o(pkt_c)
    );

    // FIFO read ports: word value is its 1-based pop index, delivered a cycle later.
    always @(posedge rclk) begin
        if (read_en_a && !rempty_a) begin
            rdata_a  <= DW'(popped_a + 1);
            popped_a <= popped_a + 1;
        end
        if (read_en_b && !rempty_b) begin
            rdata_b  <= DW'(popped_b + 1);
            popped_b <= popped_b + 1;
        end
        if (read_en_c && !rempty_c) begin
            rdata_c  <= DW'(popped_c + 1);
            popped_c <= popped_c + 1;
        end
    end

    int unsigned cyc = 0;
    always @(posedge rclk) cyc <= cyc + 1;

    // Scoreboard for build A, sampled just before each rising edge.
    int unsigned exp_next  = 1;
    int unsigned sb_beat   = 0;
    int unsigned beats     = 0;
    int unsigned lasts     = 0;
    int unsigned sb_err    = 0;
    int unsigned stab_err  = 0;
    int unsigned viol_a    = 0;
    int unsigned first_cyc = 0;
    int unsigned last_cyc  = 0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic          hold_last = 1'b0;

    always begin
        @(negedge rclk);
        #4;
        if (read_en_a && rempty_a) viol_a++;
        if (rst) begin
            // Reset discards everything already popped; resume after it.
            exp_next = popped_a + 1;
            sb_beat  = 0;
        end else begin
            if (prev_hold && (!a_if.m_valid || a_if.m_data != hold_data ||
                              a_if.m_last != hold_last)) stab_err++;
            if (a_if.m_valid && a_if.m_ready) begin
                if (a_if.m_data != DW'(exp_next)) sb_err++;
                if (a_if.m_last != (sb_beat == 15)) sb_err++;
                if (a_if.m_last) lasts++;
                if (beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                exp_next++;
                beats++;
                sb_beat = (sb_beat + 1) % 16;
            end
        end
        prev_hold = !rst && a_if.m_valid && !a_if.m_ready;
        hold_data = a_if.m_data;
        hold_last = a_if.m_last;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_beats(input int unsigned target, input int unsigned bound);
        for (int c = 0; c < int'(bound) && beats < target; c++) @(negedge rclk);
    endtask

    vec_t tbl [19];

    initial begin
        int unsigned b0, l0, nb, nc, pk;
        logic pend;
        logic [1:0] seq_c [5];

        // Back-pressure table: 10 stalled cycles then m_ready high, 8 words 0x29..0x30.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0};
        for (int i = 2; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 32'd41};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'd41};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'd42};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 32'd43};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 32'd44};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 32'd45};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 32'd46};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 32'd47};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 32'd48};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 32'h0};
        seq_c[0] = 2'd1; seq_c[1] = 2'd2; seq_c[2] = 2'd3; seq_c[3] = 2'd0; seq_c[4] = 2'd1;

        // Reset with a non-empty FIFO: no pops, outputs idle.
        loaded_a = 40;
        repeat (3) @(negedge rclk);
        #1;
        check("rst_read_en", read_en_a, 0);
        check("rst_valid", a_if.m_valid, 0);
        check("rst_last", a_if.m_last, 0);
        check("rst_pkt", pkt_a, 0);

        // 40 words streamed with m_ready high.
        @(negedge rclk);
        rst = 1'b0;
        ready_a = 1'b1;
        #1;
        check("lat_re_n", read_en_a, 1);
        check("lat_valid_n", a_if.m_valid, 0);
        @(negedge rclk); #1;
        check("lat_valid_n1", a_if.m_valid, 0);
        @(negedge rclk); #1;
        check("lat_valid_n2", a_if.m_valid, 1);
        check("lat_data_n2", a_if.m_data, 1);
        wait_beats(40, 200);
        repeat (3) @(negedge rclk);
        check("t1_beats", beats, 40);
        check("t1_lasts", lasts, 2);
        check("t1_pkt", pkt_a, 2);
        check("t1_span", last_cyc - first_cyc, 39);
        check("t1_sb", sb_err, 0);

        // Back-pressure table.
        for (int i = 0; i < 19; i++) begin
            @(negedge rclk);
            ready_a = tbl[i].ready;
            if (i == 0) loaded_a = loaded_a + 8;
            #1;
            check($sformatf("bp%0d_re", i), read_en_a, tbl[i].re);
            check($sformatf("bp%0d_valid", i), a_if.m_valid, tbl[i].valid);
            if (tbl[i].valid) check($sformatf("bp%0d_data", i), a_if.m_data, tbl[i].data);
        end
        check("bp_sb", sb_err, 0);
        check("bp_pkt", pkt_a, 3);

        // Random m_ready and FIFO-empty toggling over 1000 words.
        b0 = beats;
        @(negedge rclk);
        loaded_a = loaded_a + 1000;
        for (int c = 0; c < 20000 && beats < b0 + 1000; c++) begin
            ready_a = 1'($urandom % 2);
            gate_a  = (($urandom % 4) == 0);
            @(negedge rclk);
        end
        ready_a = 1'b1;
        gate_a  = 1'b0;
        repeat (4) @(negedge rclk);
        check("rnd_beats", beats - b0, 1000);
        check("rnd_sb", sb_err, 0);
        check("rnd_stable", stab_err, 0);
        check("rnd_re_empty", viol_a, 0);
        check("rnd_pkt", pkt_a, 65);

        // Reset while the queue holds a word and another is in flight.
        @(negedge rclk);
        ready_a = 1'b0;
        loaded_a = loaded_a + 6;
        #1 check("mr_re0", read_en_a, 1);
        @(negedge rclk); #1;
        check("mr_re1", read_en_a, 1);
        @(negedge rclk); #1;
        check("mr_valid_pre", a_if.m_valid, 1);
        check("mr_re_full", read_en_a, 0);
        rst = 1'b1;
        #1 check("mr_re_rst", read_en_a, 0);
        @(negedge rclk);
        rst = 1'b0;
        #1;
        check("mr_valid", a_if.m_valid, 0);
        check("mr_last", a_if.m_last, 0);
        check("mr_pkt", pkt_a, 0);
        b0 = beats;
        l0 = lasts;
        loaded_a = loaded_a + 12;
        ready_a = 1'b1;
        wait_beats(b0 + 16, 100);
        repeat (3) @(negedge rclk);
        check("mr_beats", beats - b0, 16);
        check("mr_lasts", lasts - l0, 1);
        check("mr_pkt_after", pkt_a, 1);
        check("mr_sb", sb_err, 0);

        // PKT_LEN=1 and 2-bit packet counter builds in parallel.
        @(negedge rclk);
        loaded_b = 5;
        loaded_c = 10;
        ready_b = 1'b1;
        ready_c = 1'b1;
        nb = 0; nc = 0; pk = 0; pend = 1'b0;
        for (int c = 0; c < 60 && !(nb == 5 && nc == 10 && !pend); c++) begin
            #1;
            if (pend) begin
                check($sformatf("c_pkt%0d", pk), pkt_c, seq_c[pk]);
                pk++;
                pend = 1'b0;
            end
            if (b_if.m_valid) begin
                check($sformatf("b_last%0d", nb), b_if.m_last, 1);
                check($sformatf("b_data%0d", nb), b_if.m_data, nb + 1);
                nb++;
            end
            if (c_if.m_valid) begin
                check($sformatf("c_last%0d", nc), c_if.m_last, (nc % 2) == 1);
                if (c_if.m_last) pend = 1'b1;
                nc++;
            end
            @(negedge rclk);
        end
        check("b_beats", nb, 5);
        check("b_pkt", pkt_b, 5);
        check("c_beats", nc, 10);
        check("c_pkts_seen", pk, 5);
        check("final_re_empty", viol_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
